// File: rtl/product_accumulator.sv
// product_accumulator: sums ACC_LEN unsigned products from the multiplier
// stage into one saturating ACC_W-bit result. The result is held until the
// consumer takes it.
//
// Handshake (both ports): a transfer happens on a rising edge exactly when
// valid and ready are both 1. in_ready is 1 only in ACCUM. out_valid is 1
// only in HOLD. A result is held stable until out_ready is seen. There is
// no bypass: in_ready stays 0 in the cycle the result is consumed.
module product_accumulator #(
  parameter int D_SIZE  = 8,
  parameter int ACC_LEN = 4,
  parameter int ACC_W   = 20
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             in_valid,
  output logic                             in_ready,
  input  logic [2*D_SIZE:0]                in_prod,
  output logic                             out_valid,
  input  logic                             out_ready,
  output logic [ACC_W-1:0]                 out_sum,
  output logic                             out_ovf,
  output logic [$clog2(ACC_LEN+1)-1:0]     count
);

  localparam int PW = 2*D_SIZE + 1;
  localparam int CW = $clog2(ACC_LEN+1);
  localparam logic [CW-1:0] LAST = CW'(ACC_LEN - 1);

  generate
    if (ACC_W < PW) begin : g_bad_acc_w
      $error("product_accumulator: ACC_W must be >= 2*D_SIZE+1");
    end
    if (ACC_LEN < 1) begin : g_bad_acc_len
      $error("product_accumulator: ACC_LEN must be >= 1");
    end
  endgenerate

  typedef enum logic {ACCUM = 1'b0, HOLD = 1'b1} state_t;

  state_t              state;
  state_t              state_next;
  logic [ACC_W-1:0]    acc;
  logic                acc_ovf;
  logic [ACC_W:0]      sum_ext;
  logic                carry;
  logic [ACC_W-1:0]    sat_sum;
  logic                xfer;
  logic                last_xfer;

  // Saturating add of the zero-extended product into the running sum.
  always_comb begin
    sum_ext = {1'b0, acc} + {{(ACC_W+1-PW){1'b0}}, in_prod};
    carry   = sum_ext[ACC_W];
    sat_sum = carry ? {ACC_W{1'b1}} : sum_ext[ACC_W-1:0];
  end

  // Next-state and handshake outputs. in_valid is ignored in HOLD, and
  // out_ready is ignored in ACCUM.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    xfer       = 1'b0;
    last_xfer  = 1'b0;
    case (state)
      ACCUM: begin
        in_ready  = 1'b1;
        xfer      = in_valid;
        last_xfer = in_valid && (count == LAST);
        if (last_xfer) state_next = HOLD;
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_next = ACCUM;
      end
      default: state_next = ACCUM;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_next;
  end

  // Accumulator, group count, sticky overflow and registered result.
  // Reset discards any partial sum or pending result.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc     <= '0;
      acc_ovf <= 1'b0;
      count   <= '0;
      out_sum <= '0;
      out_ovf <= 1'b0;
    end else if (last_xfer) begin
      out_sum <= sat_sum;
      out_ovf <= acc_ovf | carry;
      acc     <= '0;
      acc_ovf <= 1'b0;
      count   <= '0;
    end else if (xfer) begin
      acc     <= sat_sum;
      acc_ovf <= acc_ovf | carry;
      count   <= count + CW'(1);
    end
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Directed bench for product_accumulator. It uses three instances:
// the default configuration, a 17-bit accumulator for saturation, and
// ACC_LEN=1 for pass-through.
module tb_product_accumulator;

  logic clk;
  logic rst;

  // default instance (D_SIZE=8, ACC_LEN=4, ACC_W=20)
  logic        a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_ovf;
  logic [16:0] a_in_prod;
  logic [19:0] a_out_sum;
  logic [2:0]  a_count;

  // saturation instance (ACC_W=17)
  logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_ovf;
  logic [16:0] b_in_prod;
  logic [16:0] b_out_sum;
  logic [2:0]  b_count;

  // pass-through instance (ACC_LEN=1)
  logic        c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_ovf;
  logic [16:0] c_in_prod;
  logic [19:0] c_out_sum;
  logic [0:0]  c_count;

  int n_checks = 0;
  int n_pass   = 0;

  product_accumulator #(.D_SIZE(8), .ACC_LEN(4), .ACC_W(20)) u_dut_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_prod(a_in_prod),
    .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_sum(a_out_sum), .out_ovf(a_out_ovf), .count(a_count)
  );

  product_accumulator #(.D_SIZE(8), .ACC_LEN(4), .ACC_W(17)) u_dut_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_prod(b_in_prod),
    .out_valid(b_out_valid), .out_ready(b_out_ready),
    .out_sum(b_out_sum), .out_ovf(b_out_ovf), .count(b_count)
  );

  product_accumulator #(.D_SIZE(8), .ACC_LEN(1), .ACC_W(20)) u_dut_c (
    .clk(clk), .rst(rst),
    .in_valid(c_in_valid), .in_ready(c_in_ready), .in_prod(c_in_prod),
    .out_valid(c_out_valid), .out_ready(c_out_ready),
    .out_sum(c_out_sum), .out_ovf(c_out_ovf), .count(c_count)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one edge. Inputs set after this are applied on the next edge,
  // and outputs read after it reflect the edge just taken.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic send_a(input logic [16:0] p);
    a_in_valid = 1'b1;
    a_in_prod  = p;
    step();
  endtask

  task automatic send_b(input logic [16:0] p);
    b_in_valid = 1'b1;
    b_in_prod  = p;
    step();
  endtask

  // Consume the pending result of instance a and confirm the return to ACCUM.
  task automatic release_a(input string tag);
    a_in_valid  = 1'b0;
    a_out_ready = 1'b1;
    step();
    check({tag, "_rel_valid"}, 32'(a_out_valid), 32'd0);
    check({tag, "_rel_ready"}, 32'(a_in_ready), 32'd1);
  endtask

  task automatic release_b(input string tag);
    b_in_valid  = 1'b0;
    b_out_ready = 1'b1;
    step();
    check({tag, "_rel_valid"}, 32'(b_out_valid), 32'd0);
  endtask

  int exp_cnt[7];
  logic vpat[7];
  logic [16:0] gap_prod[7];

  initial begin
    rst = 1'b1;
    a_in_valid = 1'b0; a_in_prod = '0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_prod = '0; b_out_ready = 1'b0;
    c_in_valid = 1'b0; c_in_prod = '0; c_out_ready = 1'b0;

    // reset state
    step();
    step();
    check("rst_out_valid", 32'(a_out_valid), 32'd0);
    check("rst_out_sum",   32'(a_out_sum),   32'd0);
    check("rst_out_ovf",   32'(a_out_ovf),   32'd0);
    check("rst_count",     32'(a_count),     32'd0);
    rst = 1'b0;
    step();
    check("rst_in_ready",  32'(a_in_ready),  32'd1);

    // basic group 4+9+16+25
    a_out_ready = 1'b1;
    send_a(17'd4);
    check("basic_cnt1", 32'(a_count), 32'd1);
    send_a(17'd9);
    send_a(17'd16);
    check("basic_cnt3", 32'(a_count), 32'd3);
    send_a(17'd25);
    a_in_valid = 1'b0;
    check("basic_valid", 32'(a_out_valid), 32'd1);
    check("basic_sum",   32'(a_out_sum),   32'd54);
    check("basic_ovf",   32'(a_out_ovf),   32'd0);
    check("basic_ready", 32'(a_in_ready),  32'd0);
    check("basic_cnt0",  32'(a_count),     32'd0);
    release_a("basic");

    // gapped input: valid 1,0,0,1,0,1,1 with products 100,200,300,400
    vpat     = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    gap_prod = '{17'd100, 17'd0, 17'd0, 17'd200, 17'd0, 17'd300, 17'd400};
    exp_cnt  = '{1, 1, 1, 2, 2, 3, 0};
    for (int i = 0; i < 7; i++) begin
      a_in_valid = vpat[i];
      a_in_prod  = vpat[i] ? gap_prod[i] : 17'd5000;
      step();
      check($sformatf("gap_cnt%0d", i), 32'(a_count), 32'(exp_cnt[i]));
    end
    a_in_valid = 1'b0;
    check("gap_valid", 32'(a_out_valid), 32'd1);
    check("gap_sum",   32'(a_out_sum),   32'd1000);
    release_a("gap");

    // backpressure: hold 54 for three cycles, in_valid ignored in HOLD
    a_out_ready = 1'b0;
    send_a(17'd4);
    send_a(17'd9);
    send_a(17'd16);
    send_a(17'd25);
    a_in_prod = 17'd77;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("bp_valid%0d", i), 32'(a_out_valid), 32'd1);
      check($sformatf("bp_sum%0d", i),   32'(a_out_sum),   32'd54);
      check($sformatf("bp_ready%0d", i), 32'(a_in_ready),  32'd0);
      if (i < 2) step();
    end
    a_out_ready = 1'b1;
    step();
    a_in_valid = 1'b0;
    check("bp_back_ready", 32'(a_in_ready),  32'd1);
    check("bp_back_valid", 32'(a_out_valid), 32'd0);
    check("bp_back_cnt",   32'(a_count),     32'd0);

    // reset mid-group, rst beats a simultaneous transfer
    send_a(17'd7);
    send_a(17'd8);
    check("mid_cnt2", 32'(a_count), 32'd2);
    rst = 1'b1;
    a_in_prod = 17'd50;
    step();
    rst = 1'b0;
    a_in_valid = 1'b0;
    check("mid_rst_cnt",   32'(a_count),     32'd0);
    check("mid_rst_valid", 32'(a_out_valid), 32'd0);
    send_a(17'd1);
    send_a(17'd2);
    send_a(17'd3);
    send_a(17'd4);
    a_in_valid = 1'b0;
    check("mid_sum",   32'(a_out_sum),   32'd10);
    check("mid_valid", 32'(a_out_valid), 32'd1);
    release_a("mid");

    // reset while HOLD with out_ready=0 discards the pending result
    a_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_a(17'd1);
    a_in_valid = 1'b0;
    check("hrst_pre_valid", 32'(a_out_valid), 32'd1);
    check("hrst_pre_sum",   32'(a_out_sum),   32'd4);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("hrst_valid", 32'(a_out_valid), 32'd0);
    check("hrst_sum",   32'(a_out_sum),   32'd0);
    a_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("hrst_stale%0d", i), 32'(a_out_valid), 32'd0);
    end

    // saturation at ACC_W=17: 4 x 65025 saturates to 131071
    b_out_ready = 1'b0;
    for (int i = 0; i < 4; i++) send_b(17'd65025);
    b_in_valid = 1'b0;
    check("sat_valid", 32'(b_out_valid), 32'd1);
    check("sat_sum",   32'(b_out_sum),   32'd131071);
    check("sat_ovf",   32'(b_out_ovf),   32'd1);
    release_b("sat");
    // the overflow flag clears with the next group
    for (int i = 0; i < 4; i++) send_b(17'd1);
    b_in_valid = 1'b0;
    check("sat2_sum", 32'(b_out_sum), 32'd4);
    check("sat2_ovf", 32'(b_out_ovf), 32'd0);
    release_b("sat2");
    // overflow only on the final addition: 65025+65025+1000=131050, +1000 overflows
    send_b(17'd65025);
    send_b(17'd65025);
    send_b(17'd1000);
    send_b(17'd1000);
    b_in_valid = 1'b0;
    check("satlast_sum", 32'(b_out_sum), 32'd131071);
    check("satlast_ovf", 32'(b_out_ovf), 32'd1);
    release_b("satlast");

    // ACC_LEN=1 pass-through
    c_out_ready = 1'b0;
    c_in_valid  = 1'b1;
    c_in_prod   = 17'd123;
    step();
    c_in_valid = 1'b0;
    check("len1_valid", 32'(c_out_valid), 32'd1);
    check("len1_sum",   32'(c_out_sum),   32'd123);
    check("len1_ready", 32'(c_in_ready),  32'd0);
    check("len1_cnt",   32'(c_count),     32'd0);
    c_out_ready = 1'b1;
    step();
    check("len1_back", 32'(c_in_ready), 32'd1);
    c_in_valid = 1'b1;
    c_in_prod  = 17'd5;
    step();
    c_in_valid = 1'b0;
    check("len1_sum2", 32'(c_out_sum), 32'd5);
    check("len1_ovf2", 32'(c_out_ovf), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter D_SIZE, default 8: operand width of the upstream multiplier.
REQ-002 SHALL have parameter ACC_LEN, default 4: number of products summed per result; legal range >= 1.
REQ-003 SHALL have parameter ACC_W, default 20: accumulator/result width; SHALL be >= 2*D_SIZE+1 (elaboration error otherwise).
REQ-004 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1: in_prod is valid this cycle.
REQ-007 SHALL have port in_ready, output, 1: block accepts a product this cycle.
REQ-008 SHALL have port in_prod, input, 2*D_SIZE+1: unsigned product from the multiplier stage.
REQ-009 SHALL have port out_valid, output, 1: out_sum/out_ovf valid.
REQ-010 SHALL have port out_ready, input, 1: downstream consumes the result this cycle.
REQ-011 SHALL have port out_sum, output, ACC_W: unsigned sum of ACC_LEN products, saturated.
REQ-012 SHALL have port out_ovf, output, 1: saturation occurred in the presented group.
REQ-013 SHALL have port count, output, clog2(ACC_LEN+1): products accepted in the current group.

Function
REQ-014 SHALL implement two states: ACCUM and HOLD.
REQ-015 SHALL accept a product (transfer) exactly when in_valid and in_ready are both 1 on a rising edge.
REQ-016 In ACCUM, in_ready SHALL be 1 and out_valid SHALL be 0.
REQ-017 On each ACCUM transfer with count < ACC_LEN-1, SHALL add zero-extended in_prod into the accumulator and increment count.
REQ-018 On the ACCUM transfer with count == ACC_LEN-1, SHALL register accumulator+in_prod into out_sum, clear accumulator and count to 0, and enter HOLD; out_valid SHALL be 1 the following cycle (latency 1 cycle from final transfer).
REQ-019 In HOLD, in_ready SHALL be 0, out_valid SHALL be 1, and out_sum/out_ovf SHALL be stable.
REQ-020 In HOLD with out_ready = 1, SHALL return to ACCUM on that edge; in_ready SHALL stay 0 during that same cycle (no bypass); minimum group period ACC_LEN+1 cycles.
REQ-021 out_ready in ACCUM and in_valid in HOLD SHALL be ignored without side effects.
REQ-022 Cycles with in_valid = 0 in ACCUM SHALL leave accumulator and count unchanged.
REQ-023 Any addition whose true result exceeds 2^ACC_W-1 SHALL saturate the accumulator to 2^ACC_W-1 and set a sticky group overflow flag; subsequent additions in that group SHALL keep the value saturated.
REQ-024 out_ovf SHALL be the group overflow flag (including overflow on the final addition) captured with out_sum; the flag SHALL clear when the group's accumulator clears.
REQ-025 ACC_LEN = 1 SHALL pass each product to out_sum with 1-cycle latency, alternating ACCUM/HOLD.

Reset
REQ-026 While rst = 1 on a rising edge, SHALL enter ACCUM with accumulator = 0, count = 0, overflow flag = 0, out_sum = 0, out_ovf = 0, out_valid = 0; in_ready SHALL be 1 the cycle after rst deasserts.
REQ-027 Reset in any state, including mid-group or HOLD, SHALL discard the partial sum and any pending result; rst SHALL take priority over a simultaneous transfer.

Verification
REQ-028 D_SIZE=8, ACC_LEN=4, ACC_W=20: products 4, 9, 16, 25 on consecutive cycles, out_ready=1 -> out_valid=1 with out_sum=54, out_ovf=0 in the cycle after the 4th transfer; in_ready=0 in that cycle.
REQ-029 Same configuration, in_valid gapped (1,0,0,1,0,1,1) with products 100,200,300,400 -> count steps 1,1,1,2,2,3,0; out_sum=1000.
REQ-030 Backpressure: result 54 presented, out_ready=0 for 3 cycles -> out_valid, out_sum=54 held, in_ready=0 throughout; out_ready=1 -> ACCUM next cycle, in_ready=1.
REQ-031 ACC_W=17 instance: four products of 65025 -> out_sum=131071, out_ovf=1; next group 1,1,1,1 -> out_sum=4, out_ovf=0.
REQ-032 Reset mid-group: accept 7, 8, assert rst one cycle, then accept 1, 2, 3, 4 -> out_sum=10, count=0 and out_valid=0 immediately after reset.
REQ-033 Reset in HOLD with out_ready=0 -> out_valid=0 and out_sum=0 the next cycle; no stale result emitted afterwards.
